// File: rtl/ram_fifo_ctrl_if.sv
// Byte-stream handshake bundle for ram_fifo_ctrl.
// The slave modport is the FIFO side; the master modport is the producer/consumer side.
interface ram_fifo_ctrl_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// Byte FIFO over an external 1-cycle-latency RAM, with a 2-entry output buffer; 3-cycle fall-through.
// in_ready drops only when the RAM is full (or during flush); out_ready stalls reads without losing data.
module ram_fifo_ctrl #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clr,
    ram_fifo_ctrl_if.slave  bus,
    output logic [AW+1:0]   count,
    output logic            ram_we,
    output logic [AW-1:0]   ram_waddr,
    output logic [DW-1:0]   ram_wdata,
    output logic [AW-1:0]   ram_raddr,
    input  logic [DW-1:0]   ram_rdata
);
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          r_inflight;
    logic [1:0]    r_obuf_cnt;
    logic [DW-1:0] r_obuf0;
    logic [DW-1:0] r_obuf1;

    logic [AW:0]   w_ram_occ;
    logic          w_accept;
    logic          w_pop;
    logic [2:0]    w_pend;
    logic [2:0]    w_limit;
    logic          w_rd_issue;

    assign w_ram_occ = r_wptr - r_rptr;

    assign bus.in_ready = (w_ram_occ != DEPTH) && !i_clr;
    assign w_accept     = bus.in_valid && bus.in_ready;

    assign ram_we    = w_accept;
    assign ram_waddr = r_wptr[AW-1:0];
    assign ram_wdata = bus.in_data;
    assign ram_raddr = r_rptr[AW-1:0];

    assign bus.out_valid = (r_obuf_cnt != 2'd0);
    assign bus.out_data  = r_obuf0;
    assign w_pop         = bus.out_valid && bus.out_ready;

    // A pop this cycle frees a buffer slot, so a read may be issued into it immediately.
    assign w_pend     = {1'b0, r_obuf_cnt} + {2'b00, r_inflight};
    assign w_limit    = 3'd2 + {2'b00, w_pop};
    assign w_rd_issue = (w_ram_occ != '0) && (w_pend < w_limit) && !i_clr;

    assign count = {1'b0, w_ram_occ} + {{(AW+1){1'b0}}, r_inflight}
                 + {{AW{1'b0}}, r_obuf_cnt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_accept)   r_wptr <= r_wptr + 1'b1;
            if (w_rd_issue) r_rptr <= r_rptr + 1'b1;
        end
    end

    // r_obuf0 is always the head; a capture lands behind any entry that survives the pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_obuf_cnt <= 2'd0;
            r_obuf0    <= '0;
            r_obuf1    <= '0;
        end else if (i_clr) begin
            r_inflight <= 1'b0;
            r_obuf_cnt <= 2'd0;
        end else begin
            r_inflight <= w_rd_issue;
            case ({r_inflight, w_pop})
                2'b10: begin
                    if (r_obuf_cnt == 2'd0) r_obuf0 <= ram_rdata;
                    else                    r_obuf1 <= ram_rdata;
                    r_obuf_cnt <= r_obuf_cnt + 2'd1;
                end
                2'b01: begin
                    r_obuf0    <= r_obuf1;
                    r_obuf_cnt <= r_obuf_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_obuf_cnt == 2'd1) begin
                        r_obuf0 <= ram_rdata;
                    end else begin
                        r_obuf0 <= r_obuf1;
                        r_obuf1 <= ram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a behavioural RAM and a queue reference model.
module tb_ram_fifo_ctrl;
    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;
    localparam int CAP   = DEPTH + 2;

    logic            clk;
    logic            rst_n;
    logic            i_clr;
    logic [AW+1:0]   count;
    logic            ram_we;
    logic [AW-1:0]   ram_waddr;
    logic [DW-1:0]   ram_wdata;
    logic [AW-1:0]   ram_raddr;
    logic [DW-1:0]   ram_rdata;

    ram_fifo_ctrl_if #(.DW(DW)) bus ();

    ram_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (i_clr),
        .bus       (bus),
        .count     (count),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
    );

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_acc    = 0;
    logic [DW-1:0] q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes accepted and not yet delivered, in arrival order.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            chk("count_vs_model", {20'b0, count}, q.size());
            if (ram_we) chk("we_only_when_ready", {31'b0, bus.in_ready}, 1);
            if (q.size() < DEPTH && !i_clr) chk("ready_not_full", {31'b0, bus.in_ready}, 1);
            if (q.size() == CAP) chk("ready_at_capacity", {31'b0, bus.in_ready}, 0);
            if (i_clr) begin
                q.delete();
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    if (q.size() == 0) chk("pop_from_empty_model", 1, 0);
                    else chk("out_data_order", {24'b0, bus.out_data}, {24'b0, q.pop_front()});
                end
                if (bus.in_valid && bus.in_ready) begin
                    q.push_back(bus.in_data);
                    n_acc++;
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single_byte(input logic [7:0] d);
        int lat;
        tick();
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk("single_latency", lat, 3);
        chk("single_data", {24'b0, bus.out_data}, {24'b0, d});
        tick();
        chk("single_then_empty", {31'b0, bus.out_valid}, 0);
    endtask

    task automatic drain();
        int n;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        tick();
        chk("drain_complete", q.size(), 0);
        chk("drain_out_valid", {31'b0, bus.out_valid}, 0);
    endtask

    initial begin
        int base;
        int bubbles;
        int maxc;
        rst_n         = 1'b0;
        i_clr         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #2;
        chk("rst_out_valid", {31'b0, bus.out_valid}, 0);
        chk("rst_out_data", {24'b0, bus.out_data}, 0);
        chk("rst_count", {20'b0, count}, 0);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 1);
        chk("rst_ram_we", {31'b0, ram_we}, 0);
        #20 rst_n = 1'b1;

        single_byte(8'h5A);

        // Fill to capacity with the consumer stalled, then drain.
        tick();
        bus.out_ready = 1'b0;
        base = n_acc;
        for (int i = 0; i < 1100; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(n_acc - base);
            tick();
        end
        chk("fill_accepted", n_acc - base, CAP);
        chk("fill_in_ready", {31'b0, bus.in_ready}, 0);
        chk("fill_count", {20'b0, count}, CAP);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("full_ready_at_issue", {31'b0, bus.in_ready}, 0);
        tick();
        chk("ready_after_issue", {31'b0, bus.in_ready}, 1);
        drain();

        // Continuous streaming: no bubbles after the initial latency.
        tick();
        bubbles = 0;
        maxc    = 0;
        for (int i = 0; i < 3010; i++) begin
            bus.in_valid  = (i < 3000);
            bus.in_data   = 8'(i);
            bus.out_ready = 1'b1;
            #1;
            if (i >= 3 && i < 3003 && !bus.out_valid) bubbles++;
            if (i < 3000 && !bus.in_ready) bubbles++;
            if (int'(count) > maxc) maxc = int'(count);
            tick();
        end
        chk("stream_bubbles", bubbles, 0);
        chk("stream_count_le3", {31'b0, maxc <= 3}, 1);
        drain();

        // Random backpressure: balanced, then consumer-starved so the FIFO fills.
        maxc = 0;
        for (int i = 0; i < 6000; i++) begin
            if (i < 3000) begin
                bus.in_valid  = ($urandom_range(0, 1) == 1);
                bus.out_ready = ($urandom_range(0, 1) == 1);
            end else begin
                bus.in_valid  = ($urandom_range(0, 3) != 0);
                bus.out_ready = ($urandom_range(0, 3) == 0);
            end
            bus.in_data = 8'($urandom);
            #1;
            if (int'(count) > maxc) maxc = int'(count);
            tick();
        end
        chk("random_max_count", {31'b0, maxc <= CAP}, 1);
        chk("random_reached_full", maxc, CAP);
        drain();

        // Flush with 10 bytes held and a RAM read in flight.
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;
        repeat (5) tick();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h11;
        tick();
        i_clr        = 1'b1;
        bus.in_data  = 8'h22;
        #1;
        chk("clr_in_ready", {31'b0, bus.in_ready}, 0);
        chk("clr_ram_we", {31'b0, ram_we}, 0);
        chk("clr_count_before", {20'b0, count}, 10);
        tick();
        i_clr         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("clr_out_valid", {31'b0, bus.out_valid}, 0);
        chk("clr_count", {20'b0, count}, 0);
        repeat (3) tick();
        chk("clr_stays_empty", {31'b0, bus.out_valid}, 0);
        single_byte(8'hA5);

        // Asynchronous reset in the middle of a stream.
        tick();
        for (int i = 0; i < 20; i++) begin
            bus.in_valid  = 1'b1;
            bus.out_ready = ($urandom_range(0, 1) == 1);
            bus.in_data   = 8'($urandom);
            tick();
        end
        #1 rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("arst_out_valid", {31'b0, bus.out_valid}, 0);
        chk("arst_count", {20'b0, count}, 0);
        chk("arst_in_ready", {31'b0, bus.in_ready}, 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        single_byte(8'hC3);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
Byte-stream FIFO controller that uses the 1024-byte dual-read-port RAM as its storage array. It accepts bytes on a valid/ready input and drives the RAM write port and read port 1. It absorbs the RAM's registered one-cycle read latency with a 2-entry output buffer, so it delivers one byte per cycle on a valid/ready output. It sits between byte producers (UART RX, debug bridge) and byte consumers (bus-side reader, UART TX).

Parameters:
AW, 10, RAM address width; RAM depth DEPTH = 2**AW bytes (1024).
DW, 8, data width in bits.

Ports:
clk  input  1  clock
rst_n  input  1  reset
i_clr  input  1  synchronous flush; discards all contents
in_valid  input  1  producer has a byte
in_ready  output  1  block accepts a byte this cycle
in_data  input  DW  byte in
out_valid  output  1  out_data is valid
out_ready  input  1  consumer takes the byte this cycle
out_data  output  DW  byte out (head of FIFO)
count  output  AW+2  total bytes held (RAM + in flight + output buffer)
ram_we  output  1  to RAM i_we
ram_waddr  output  AW  to RAM i_waddr
ram_wdata  output  DW  to RAM i_wdata
ram_raddr  output  AW  to RAM i_raddr
ram_rdata  input  DW  from RAM o_rdata; valid 1 cycle after ram_raddr is sampled

Behaviour:
- Reset rst_n is asynchronous, active-low; clock clk. Reset clears wptr, rptr, inflight, obuf_cnt and obuf contents to 0.
- Outputs in and after reset: out_valid=0, out_data=0, count=0, in_ready=1, ram_we=0.
- Pointers wptr and rptr are AW+1 bits. ram_occ = wptr - rptr (0..DEPTH), computed from registered values only.
- in_ready = (ram_occ != DEPTH) and not i_clr. This is combinational and does not depend on in_valid.
- Write path: accept = in_valid & in_ready.
  - ram_we = accept; ram_waddr = wptr[AW-1:0]; ram_wdata = in_data; all combinational.
  - wptr increments on the next edge.
- Read issue: rd_issue = (ram_occ != 0) & (obuf_cnt + inflight + pop_adj < 2) & not i_clr.
  - pop_adj = -1 when the output pops this cycle, else 0.
  - ram_raddr = rptr[AW-1:0] (combinational). On rd_issue, rptr increments and inflight is set to 1 on the next edge; otherwise inflight clears.
- Capture: in the cycle where inflight=1, ram_rdata is pushed into the 2-entry output buffer at the next edge.
- Output: out_valid = (obuf_cnt != 0); out_data = obuf head. pop = out_valid & out_ready.
  - Simultaneous capture and pop is allowed; the FIFO order is preserved.
- Write/read same address: an entry written at edge t is counted in ram_occ only from cycle t+1. A read issued in cycle t+1 or later samples after the write completed, so no read-during-write hazard exists.
- Latency: a byte accepted at edge t is out_valid in cycle t+3 (empty FIFO, out_ready=1). Sustained throughput is 1 byte/cycle in both directions simultaneously.
- Capacity: DEPTH + 2 bytes (RAM full plus output buffer full). count = ram_occ + inflight + obuf_cnt.
- Wrap-around: pointer low bits wrap from DEPTH-1 to 0; the MSB distinguishes full from empty.
- i_clr (synchronous, priority over all else):
  - In-cycle: forces in_ready=0 and ram_we=0, and suppresses rd_issue.
  - At the next edge: wptr=rptr=0, inflight=0, obuf_cnt=0. Any in-flight RAM read data is discarded.
  - out_valid may still be 1 during the i_clr cycle, but a pop in that cycle has no further effect.
- Reset mid-operation: all state returns to the reset values immediately. RAM contents are ignored afterwards (treated as empty).

Test Plan:
- Single byte: write 0x5A at edge 0 with out_ready=1 -> out_valid=1 and out_data=0x5A in cycle 3, then out_valid=0 next cycle; count goes 1 then 0.
- Fill: out_ready=0, stream bytes 0..0xFF repeating -> exactly 1026 accepted; in_ready=0 afterwards; count=1026. Then drain -> bytes emerge in order, and in_ready returns to 1 one cycle after the first RAM read issue.
- Streaming: in_valid=1 and out_ready=1 continuously for 3000 bytes (incrementing) -> no bubbles after initial latency 3, output identical and in order, pointers wrap twice, count steady at 3 or less.
- Backpressure: random out_ready (50%) with random in_valid -> scoreboard matches order; count never exceeds 1026; ram_we never asserted while in_ready=0.
- Flush: 10 bytes held with a read in flight, assert i_clr one cycle -> next cycle out_valid=0, count=0. A subsequent write of 0xA5 emerges as the first byte.
- Async reset mid-stream: drop rst_n between edges -> out_valid=0, count=0 and in_ready=1 immediately. After release, new data passes with latency 3.
